// File: rtl/mem_io_responder_pkg.sv
// Shared constants for the CPU-side memory/IO responder: I/O decode select,
// register addresses and bus widths.
package mem_io_responder_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  localparam logic [1:0]  IO_SEL       = 2'b11;
  localparam logic [17:0] IO_UART_ADDR = 18'h30000;
  localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;

endpackage

// File: rtl/mem_io_responder_fifo.sv
// resp_fifo: synchronous FIFO with combinational head and next-count output.
// A pop frees its slot before the push in the same cycle, so push+pop while
// full is accepted. Pushes while full (without pop) and pops while empty are
// ignored.
module resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count_next,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign do_pop     = pop & ~empty;
  assign do_push    = push & (~full | do_pop);
  assign count_next = count + CW'(do_push) - CW'(do_pop);
  assign head       = store[rd_ptr];

  // Pointers and occupancy; cleared by reset so any in-flight entry is lost.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
    end
  end

  // Entry storage, not reset.
  always_ff @(posedge clk_in) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: target side of the CPU byte bus. 128 KB RAM with one-cycle
// read latency plus memory-mapped I/O at mem_a[17:16]==2'b11 (UART TX/RX
// FIFOs, free-running cycle counter with snapshot, sticky program-stop flag).
// Optional: define MEM_IO_BUS_ERR_EN to add a sticky bus_err output and make
// out-of-range RAM reads return 0xFF instead of aliasing.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_W = 17,
  parameter int TX_DEPTH   = 16,
  parameter int RX_DEPTH   = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [WORD_W-1:0] mem_a,
  input  logic [BYTE_W-1:0] mem_dout,
  input  logic              mem_wr,
  input  logic              mem_rd,
  output logic [BYTE_W-1:0] mem_din,
  output logic              io_buffer_full,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              prog_stop
`ifdef MEM_IO_BUS_ERR_EN
  ,
  output logic              bus_err
`endif
);

  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;

  logic [BYTE_W-1:0] ram [2**RAM_ADDR_W];

  logic [17:0]       a18;
  logic              is_io;
  logic              rd_req;
  logic              oor;
  logic              ram_we;
  logic [WORD_W-1:0] cyc_cnt;
  logic [31:8]       snap;
  logic [BYTE_W-1:0] rd_byte;

  logic              tx_push_req, tx_push, tx_pop, tx_full, tx_empty;
  logic [BYTE_W-1:0] tx_push_data;
  logic [TX_CW-1:0]  tx_count_next;
  logic              rx_pop_req, rx_pop, rx_push, rx_full, rx_empty;
  logic [BYTE_W-1:0] rx_head;
  logic [RX_CW-1:0]  rx_count_next;

  assign a18    = mem_a[17:0];
  assign is_io  = (a18[17:16] == IO_SEL);
  assign rd_req = mem_rd & ~mem_wr;   // write wins; a write cycle has no read side effects

`ifdef MEM_IO_BUS_ERR_EN
  assign oor = ~is_io & ((a18[17:16] == 2'b10) | (mem_a[31:18] != '0));
`else
  logic unused_hi_addr;
  assign unused_hi_addr = ^mem_a[31:18];
  assign oor = 1'b0;
`endif

  assign ram_we = mem_wr & ~is_io & ~oor;

  // 0x30000 pushes non-zero bytes; 0x30004 pushes a 0x00 marker alongside stop.
  assign tx_push_req  = mem_wr & is_io &
                        (((a18 == IO_UART_ADDR) & (mem_dout != '0)) | (a18 == IO_CLK_ADDR));
  assign tx_push_data = (a18 == IO_CLK_ADDR) ? '0 : mem_dout;
  assign tx_valid     = ~tx_empty;
  assign tx_pop       = tx_valid & tx_ready;
  assign tx_push      = tx_push_req & (~tx_full | tx_pop);

  assign rx_pop_req = rd_req & is_io & (a18 == IO_UART_ADDR);
  assign rx_pop     = rx_pop_req & ~rx_empty;
  assign rx_push    = rx_valid & rx_ready & ~rx_full;

  resp_fifo #(.WIDTH(BYTE_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .push       (tx_push),
    .push_data  (tx_push_data),
    .pop        (tx_pop),
    .head       (tx_data),
    .count_next (tx_count_next),
    .full       (tx_full),
    .empty      (tx_empty)
  );

  resp_fifo #(.WIDTH(BYTE_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .push       (rx_push),
    .push_data  (rx_data),
    .pop        (rx_pop),
    .head       (rx_head),
    .count_next (rx_count_next),
    .full       (rx_full),
    .empty      (rx_empty)
  );

  // RAM write port; contents survive reset.
  always_ff @(posedge clk_in) begin
    if (ram_we) ram[mem_a[RAM_ADDR_W-1:0]] <= mem_dout;
  end

  // Read data select for the byte returned next cycle.
  always_comb begin
    rd_byte = '0;
    if (!is_io) begin
      rd_byte = oor ? 8'hFF : ram[mem_a[RAM_ADDR_W-1:0]];
    end else begin
      case (a18)
        IO_UART_ADDR:        rd_byte = rx_empty ? '0 : rx_head;
        IO_CLK_ADDR:         rd_byte = cyc_cnt[7:0];
        IO_CLK_ADDR + 18'd1: rd_byte = snap[15:8];
        IO_CLK_ADDR + 18'd2: rd_byte = snap[23:16];
        IO_CLK_ADDR + 18'd3: rd_byte = snap[31:24];
        default:             rd_byte = '0;
      endcase
    end
  end

  // Registered bus outputs, counter/snapshot, stop flag and FIFO status flags.
  // Status flags come from next-state counts so they line up with occupancy.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_din        <= '0;
      cyc_cnt        <= '0;
      snap           <= '0;
      prog_stop      <= 1'b0;
      io_buffer_full <= 1'b0;
      rx_ready       <= 1'b0;
    end else begin
      if (rd_req) mem_din <= rd_byte;
      cyc_cnt <= cyc_cnt + 32'd1;
      if (rd_req & is_io & (a18 == IO_CLK_ADDR)) snap <= cyc_cnt[31:8];
      if (mem_wr & is_io & (a18 == IO_CLK_ADDR)) prog_stop <= 1'b1;
      io_buffer_full <= (tx_count_next >= TX_CW'(TX_DEPTH - 2));
      rx_ready       <= (rx_count_next != RX_CW'(RX_DEPTH));
    end
  end

`ifdef MEM_IO_BUS_ERR_EN
  // Sticky error: out-of-range RAM access, dropped TX push, or RX read while empty.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bus_err <= 1'b0;
    end else if (((mem_wr | mem_rd) & oor) |
                 (tx_push_req & tx_full & ~tx_pop) |
                 (rx_pop_req & rx_empty)) begin
      bus_err <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Target side of the CPU byte bus (mem_a / mem_dout / mem_wr / mem_din / io_buffer_full).
- Serves 128 KB RAM with 1-cycle read latency, plus memory-mapped I/O at mem_a[17:16]==2'b11:
  - UART TX/RX byte FIFOs.
  - Cycle counter.
  - Program-stop flag.
- Sits between cpu and the UART/host link in the top-level harness.

Parameters:
- RAM_ADDR_W, 17, byte-address width of internal RAM (2^17 = 128 KB).
- TX_DEPTH, 16, TX FIFO entries (power of 2, >=4).
- RX_DEPTH, 16, RX FIFO entries (power of 2, >=2).

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset, asynchronous, active-low.
- mem_a  in  32  byte address from CPU (bits 17:0 decoded).
- mem_dout  in  8  write data from CPU.
- mem_wr  in  1  1 = write this cycle.
- mem_rd  in  1  1 = read request this cycle (needed so read side effects fire once).
- mem_din  out  8  read data, valid the cycle after the request.
- io_buffer_full  out  1  TX FIFO almost full.
- tx_data  out  8  byte to UART transmitter.
- tx_valid  out  1  TX FIFO non-empty.
- tx_ready  in  1  UART accepts tx_data when tx_valid&tx_ready.
- rx_data  in  8  byte from UART receiver.
- rx_valid  in  1  rx_data valid; accepted when rx_valid&rx_ready.
- rx_ready  out  1  RX FIFO not full.
- prog_stop  out  1  sticky, program requested stop.

Behaviour:
- Reset (rst_in=0, async): all outputs 0 (mem_din=0, io_buffer_full=0, tx_valid=0, rx_ready=0, prog_stop=0); FIFOs emptied; counter=0; snapshot=0. RAM contents not reset.
- Decode:
  - io = (mem_a[17:16]==2'b11).
  - RAM index = mem_a[RAM_ADDR_W-1:0].
  - mem_wr and mem_rd both 1: write wins; no read side effects.
- RAM write: mem_wr & !io -> byte written at clock edge.
- RAM read: mem_rd & !io -> mem_din = RAM[index] next cycle.
  - Read-after-write to the same address in consecutive cycles returns the new byte.
- 0x30000 write:
  - Nonzero byte -> push TX FIFO. 0x00 ignored.
  - Push while TX full: byte dropped, no other effect.
- 0x30000 read: mem_din next cycle = RX head, with a pop. RX empty -> mem_din=0x00, no pop.
- 0x30004 write: prog_stop<=1 (sticky until reset); push 0x00 into TX FIFO (dropped if full).
- Cycle counter (32-bit):
  - Increments every cycle out of reset; wraps 0xFFFFFFFF->0.
  - Read 0x30004: snapshot<=counter; mem_din=counter[7:0] (current value).
  - Reads 0x30005/6/7 return snapshot[15:8]/[23:16]/[31:24]; no snapshot update.
- Other io addresses: read -> 0x00; write -> ignored.
- When no read occurs: mem_din holds its last value.
- io_buffer_full = registered (tx_count >= TX_DEPTH-2).
  - The 2-entry margin covers the CPU's one-cycle reaction latency.
- TX FIFO:
  - tx_valid = !empty; tx_data = head (combinational from storage).
  - Push and pop in the same cycle: count unchanged, both take effect (legal even when full, since pop frees a slot first).
- RX FIFO:
  - rx_ready = !full (registered from count).
  - Push from rx_valid&rx_ready and pop from CPU read in the same cycle: count unchanged.
- Reset asserted mid-transfer: FIFOs cleared; in-flight byte lost; no partial state.

Optional Feature:
- Macro: MEM_IO_BUS_ERR_EN.
- Defined: adds output bus_err (1 bit, reset 0, sticky). Set when any of:
  - RAM access with mem_a[17:16]==2'b10, or mem_a[31:18]!=0;
  - TX push dropped because full;
  - RX read when empty.
  - Out-of-range reads then return 0xFF instead of aliasing.
- Undefined:
  - No bus_err port.
  - Out-of-range addresses alias modulo 2^RAM_ADDR_W.
  - Overflow/underflow silent as above.

Decomposition:
- Shared package/header (alongside macro.v), constants:
  - IO_UART_ADDR = 18'h30000
  - IO_CLK_ADDR = 18'h30004
  - IO_SEL = 2'b11
  - byte/word widths
- Sub-module: resp_fifo (parameterised width/depth synchronous FIFO with count, push/pop, full/empty), instantiated twice for TX and RX.

Test Plan:
- RAM: write 0xA5 @0x00010, read @0x00010 next cycle -> mem_din=0xA5 one cycle after request; read @0x1FFFF after write 0x3C -> 0x3C.
- TX: hold tx_ready=0, write 'H','i',0x00 to 0x30000 -> TX count 2, tx_data='H'; then tx_ready=1 -> 'H','i' out in order, tx_valid drops.
- TX full: tx_ready=0, write 14 bytes -> io_buffer_full=1 after 14th (TX_DEPTH=16); 17th write dropped; count stays 16.
- RX: drive rx_valid with 0x41,0x42 -> reads of 0x30000 return 0x41, 0x42, then 0x00 on empty.
- Counter: after 100 cycles out of reset, read 0x30004..0x30007 in consecutive cycles -> bytes form the snapshot value, with byte 0 equal to the value latched; counter wrap checked by forcing 0xFFFFFFFF -> 0.
- Stop: write 0x30004 -> prog_stop=1, 0x00 appears on tx_data; assert rst_in=0 mid-stream -> prog_stop=0, tx_valid=0 immediately (async).
